mem_seq_ctrl: RTL and testbench
===============================

Name: mem_seq_ctrl

Overview:
- Sequencer for the vector ASIP data memory.
- Walks a 2-D index space (i row, j column, both 0..n-1), driving the memory's i/j/n load indices one 4-lane chunk at a time.
- Waits a fixed datapath latency for lane results, then issues one write-only-memory (WOM) write per chunk with the matching linear address.
- Sits between the core's start/done control and the Memory block's i, j, n, wr_wom, wom_addr inputs.

Parameters:
- LANES, 4, lanes per chunk; j and wom_addr advance by LANES; must be a power of two.
- LAT, 2, cycles from load issue to valid lane results (1..15).
- W, 32, width of index and address buses.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run when IDLE; ignored otherwise
- n_cfg  in  W  matrix dimension, sampled on accepted start
- stall  in  1  back-pressure; freezes the FSM and counters while high
- i  out  W  row index to Memory
- j  out  W  column index of lane 0 to Memory
- n  out  W  registered copy of n_cfg
- wr_wom  out  1  WOM write strobe, exactly one cycle per chunk
- wom_addr  out  W  linear address i*n+j of lane 0, valid with wr_wom
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse at end of run
- err  out  1  sticky; set if n_cfg is not a multiple of LANES; cleared on the next accepted start

Behaviour:
- Reset (asynchronous, any state): state=IDLE; i, j, n, wom_addr, wait counter = 0; wr_wom, busy, done, err = 0. Reset mid-run aborts with no further write.
- IDLE:
  - start with n_cfg==0 -> DONE (no writes).
  - start with n_cfg % LANES != 0 -> err=1, DONE.
  - otherwise latch n, clear i/j/wom_addr -> LOAD.
- LOAD: i/j are stable on the outputs for this cycle; load wait counter = LAT-1 -> WAIT.
- WAIT: decrement counter; at 0 -> WRITE.
- WRITE: wr_wom=1 for this cycle, wom_addr is the current value.
  - j+LANES < n: j += LANES, wom_addr += LANES -> LOAD.
  - else if i+1 < n: j=0, i+=1, wom_addr += LANES -> LOAD.
  - else -> DONE.
- DONE: done=1 for one cycle; busy=0 -> IDLE.
- Addressing: wom_addr is maintained by increment only (no multiplier); it equals i*n+j at every WRITE. Arithmetic is modulo 2^W.
- Per-chunk cost: 1+LAT cycles plus the WRITE cycle. A run with n>0 takes (n*n/LANES)*(LAT+2)+1 cycles from the start edge to the done pulse.
- stall: while high, state, counters and outputs hold. wr_wom is forced 0, and the WRITE repeats in full once stall drops. done is not asserted during stall.
- start while busy: ignored, no effect on n or err.
- start in the same cycle done is high: ignored; the next start is accepted in IDLE.
- i, j, n, wom_addr hold their last values after DONE.

Optional Feature:
- Macro MEM_SEQ_PERF_EN.
- Defined:
  - Adds output stall_cycles (W): counts cycles with busy && stall; cleared on accepted start and on reset; saturates at all-ones.
  - Adds output chunk_cnt (W): counts WRITEs.
- Undefined: neither port nor counter exists; all other behaviour identical.

Decomposition:
- Package mem_seq_pkg holds:
  - state enum typedef {IDLE, LOAD, WAIT, WRITE, DONE};
  - default LANES/LAT constants;
  - localparam for the wait-counter width (4 bits).
- One sub-module, mem_seq_idx: the i/j/wom_addr increment-and-wrap logic with inputs step, clear, n. The FSM stays in mem_seq_ctrl.

Test Plan:
- Reset mid-run: with n=8, assert rst during the 3rd WAIT -> all outputs 0 and state IDLE the same cycle; no wr_wom afterwards.
- Nominal: n=8, LAT=2, start pulse -> 16 wr_wom pulses; wom_addr = 0,4,8,...,60; (i,j) = (0,0),(0,4),(1,0)...(7,4); done pulses at cycle 65 after start; err=0.
- Zero and bad size:
  - n=0 -> done the cycle after start, no writes.
  - n=6 -> err=1, done, no writes.
  - Next start with n=4 -> err cleared, 4 writes, addrs 0,4,8,12.
- Stall: n=4, hold stall for 5 cycles during the 2nd WRITE -> wr_wom low throughout the stall, then one write at addr 4; total writes 4; run lengthened by exactly 5 cycles.
- start while busy: pulse start with n_cfg=16 mid-run of n=8 -> ignored; run completes with n=8 results only.
- With MEM_SEQ_PERF_EN: the stall scenario above gives stall_cycles=5 and chunk_cnt=4 at done.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared state encoding and default constants for the memory sequencer.
package mem_seq_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, WRITE, DONE} state_e;

    localparam int LANES_DEF = 4;
    localparam int LAT_DEF   = 2;
    localparam int CNT_W     = 4;

endpackage

// File: rtl/mem_seq_idx.sv
// mem_seq_idx: row/column/linear-address walker; advances one LANES-wide chunk per step.
module mem_seq_idx
    import mem_seq_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         clear,
    input  logic [W-1:0] n,
    output logic [W-1:0] i,
    output logic [W-1:0] j,
    output logic [W-1:0] addr,
    output logic         last
);
    logic [W-1:0] i_q, i_d, j_q, j_d, a_q, a_d;
    logic         j_wrap;

    assign j_wrap = j_q + W'(LANES) >= n;
    assign last   = j_wrap && !(i_q + W'(1) < n);

    // n is a multiple of LANES, so the linear address simply keeps incrementing across a row wrap
    always_comb begin
        i_d = clear ? '0 : (step && j_wrap) ? i_q + W'(1) : i_q;
        j_d = clear ? '0 : step ? (j_wrap ? '0 : j_q + W'(LANES)) : j_q;
        a_d = clear ? '0 : step ? a_q + W'(LANES) : a_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            i_q <= '0;
            j_q <= '0;
            a_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            a_q <= a_d;
        end

    assign i    = i_q;
    assign j    = j_q;
    assign addr = a_q;

endmodule

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: 2-D load/WOM-write sequencer for the vector ASIP data memory.
// Define MEM_SEQ_PERF_EN to add the stall_cycles and chunk_cnt counters.
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] n_cfg,
    input  logic         stall,
    output logic [W-1:0] i,
    output logic [W-1:0] j,
    output logic [W-1:0] n,
    output logic         wr_wom,
    output logic [W-1:0] wom_addr,
    output logic         busy,
    output logic         done,
    output logic         err
`ifdef MEM_SEQ_PERF_EN
    ,
    output logic [W-1:0] stall_cycles,
    output logic [W-1:0] chunk_cnt
`endif
);
    localparam logic [W-1:0] MASK = W'(LANES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     n_q, n_d;
    logic             wr_q, wr_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             accept, ok, step, clear, last;

    assign accept = state_q == IDLE && start && !stall;
    assign ok     = n_cfg != '0 && (n_cfg & MASK) == '0;
    assign clear  = accept && ok;
    assign step   = state_q == WRITE && !stall && !last;

    mem_seq_idx #(.LANES(LANES), .W(W)) u_idx (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .clear(clear),
        .n    (n_q),
        .i    (i),
        .j    (j),
        .addr (wom_addr),
        .last (last)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        err_d   = err_q;
        if (!stall) begin
            unique case (state_q)
                IDLE: if (start) begin
                    err_d   = (n_cfg & MASK) != '0;
                    n_d     = ok ? n_cfg : n_q;
                    state_d = ok ? LOAD : DONE;
                end
                LOAD: begin
                    cnt_d   = CNT_W'(LAT - 1);
                    state_d = WAIT;
                end
                WAIT: begin
                    cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
                    state_d = cnt_q == '0 ? WRITE : WAIT;
                end
                WRITE:   state_d = last ? DONE : LOAD;
                default: state_d = IDLE;
            endcase
        end
        wr_d   = state_d == WRITE;
        busy_d = state_d inside {LOAD, WAIT, WRITE};
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end

    // a stalled WRITE or DONE stays in place but must not strobe
    assign wr_wom = wr_q && !stall;
    assign done   = done_q && !stall;
    assign busy   = busy_q;
    assign err    = err_q;
    assign n      = n_q;

`ifdef MEM_SEQ_PERF_EN
    logic [W-1:0] stall_q, stall_d, chunk_q, chunk_d;

    always_comb begin
        stall_d = accept ? '0 : (busy_q && stall && !(&stall_q)) ? stall_q + W'(1) : stall_q;
        chunk_d = accept ? '0 : (state_q == WRITE && !stall) ? chunk_q + W'(1) : chunk_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stall_q <= '0;
            chunk_q <= '0;
        end else begin
            stall_q <= stall_d;
            chunk_q <= chunk_d;
        end

    assign stall_cycles = stall_q;
    assign chunk_cnt    = chunk_q;
`endif

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb_mem_seq_ctrl: randomized bench for mem_seq_ctrl against a timeline model of chunk progress.
// Builds with or without MEM_SEQ_PERF_EN.
module tb_mem_seq_ctrl;
    import mem_seq_pkg::*;

    localparam int W     = 32;
    localparam int LANES = LANES_DEF;
    localparam int LAT   = LAT_DEF;
    localparam int PER   = LAT + 2;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, stall = 1'b0;
    logic [W-1:0] n_cfg = '0;
    logic [W-1:0] i, j, n, wom_addr;
    logic         wr_wom, busy, done, err;
`ifdef MEM_SEQ_PERF_EN
    logic [W-1:0] stall_cycles, chunk_cnt;
`endif
    int n_tests = 0, n_fail = 0;

    mem_seq_ctrl #(.LANES(LANES), .LAT(LAT), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .n_cfg       (n_cfg),
        .stall       (stall),
        .i           (i),
        .j           (j),
        .n           (n),
        .wr_wom      (wr_wom),
        .wom_addr    (wom_addr),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef MEM_SEQ_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .chunk_cnt   (chunk_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string ph);
        check({ph, "_i"}, i, '0);
        check({ph, "_j"}, j, '0);
        check({ph, "_n"}, n, '0);
        check({ph, "_addr"}, wom_addr, '0);
        check({ph, "_wr"}, W'(wr_wom), '0);
        check({ph, "_busy"}, W'(busy), '0);
        check({ph, "_done"}, W'(done), '0);
        check({ph, "_err"}, W'(err), '0);
    endtask

    // The run is a sequence of unit cycles: PER per chunk plus the DONE cycle.
    // Each unstalled cycle consumes one unit; chunk m writes on unit (m+1)*PER.
    task automatic run(input int nn, input int st_at, input int st_len, input int st_pct,
                       input int sp_at, input bit rnd_start);
        int chunks, total, p, sc;
        bit ok, is_wr, is_done;
        logic [W-1:0] lin;
        ok     = nn > 0 && nn % LANES == 0;
        chunks = ok ? nn * nn / LANES : 0;
        total  = chunks * PER + 1;
        p      = 0;
        sc     = 0;
        @(posedge clk); #1;
        start = 1'b1;
        n_cfg = W'(nn);
        stall = 1'b0;
        for (int k = 1; k < 5000 && p < total; k++) begin
            @(posedge clk); #1;
            start = (k == sp_at) || (rnd_start && $urandom_range(7) == 0);
            n_cfg = (k == sp_at) ? W'(16) : W'($urandom_range(1, 20));
            stall = (k >= st_at && k < st_at + st_len) || ($urandom_range(99) < st_pct);
            @(negedge clk);
            is_wr   = !stall && (p + 1) % PER == 0 && p + 1 <= chunks * PER;
            is_done = !stall && p + 1 == total;
            if (stall && p + 1 < total) sc++;
            check("busy", W'(busy), W'(p + 1 < total));
            check("wr_wom", W'(wr_wom), W'(is_wr));
            check("done", W'(done), W'(is_done));
            if (is_wr) begin
                lin = W'(((p + 1) / PER - 1) * LANES);
                check("wom_addr", wom_addr, lin);
                check("i", i, lin / W'(nn));
                check("j", j, lin % W'(nn));
            end
            if (!stall) p++;
        end
        check("run_complete", W'(p), W'(total));
        check("err", W'(err), W'(nn % LANES != 0));
        if (ok) begin
            check("n_hold", n, W'(nn));
            check("i_hold", i, W'(nn - 1));
            check("j_hold", j, W'(nn - LANES));
            check("addr_hold", wom_addr, W'(nn * nn - LANES));
        end
`ifdef MEM_SEQ_PERF_EN
        check("stall_cycles", stall_cycles, W'(sc));
        check("chunk_cnt", chunk_cnt, W'(chunks));
`endif
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic run_reset;
        @(posedge clk); #1;
        start = 1'b1;
        n_cfg = W'(8);
        repeat (6) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("post_rst_wr", W'(wr_wom), '0);
            check("post_rst_busy", W'(busy), '0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        run(8, 0, 0, 0, 0, 1'b0);
        run(0, 0, 0, 0, 0, 1'b0);
        run(6, 0, 0, 0, 0, 1'b0);
        run(4, 0, 0, 0, 0, 1'b0);
        run(4, 2 * PER, 5, 0, 0, 1'b0);
        run(8, 0, 0, 0, 10, 1'b0);
        run_reset();
        run(8, 0, 0, 0, 0, 1'b0);
        for (int r = 0; r < 20; r++)
            run(($urandom_range(9) == 0) ? int'($urandom_range(1, 15)) : 4 * int'($urandom_range(0, 4)),
                0, 0, 25, 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
